// File: rtl/down_cnt_pkg.sv
// Shared constants and FSM state type for the down-counter monitor.
package down_cnt_pkg;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } mon_state_t;
endpackage

// File: rtl/down_count_monitor_if.sv
// Wrap-event port: the monitor (master) offers evt_wraps, the consumer (slave) accepts it.
// A transfer occurs on a rising edge where evt_valid && evt_ready; while evt_valid is high
// and evt_ready is low, evt_wraps is held stable and evt_valid does not drop.
interface down_count_monitor_if #(
  parameter int WRAP_W = 8
);
  logic              evt_valid;
  logic              evt_ready;
  logic [WRAP_W-1:0] evt_wraps;

  modport master (output evt_valid, output evt_wraps, input evt_ready);
  modport slave  (input evt_valid, input evt_wraps, output evt_ready);
endinterface

// File: rtl/down_count_monitor_evt_fifo2.sv
// Two-entry valid/ready FIFO; slot s0 is always the head, so head outputs come straight from flops.
module evt_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data
);
  logic [1:0]   cnt;
  logic [W-1:0] s0, s1;
  logic         pop_eff, push_eff;

  assign pop_eff    = pop && (cnt != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_eff   = push && ((cnt != 2'd2) || pop_eff);
  assign full       = (cnt == 2'd2);
  assign head_valid = (cnt != 2'd0);
  assign head_data  = s0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 2'd0;
      s0  <= '0;
      s1  <= '0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (cnt == 2'd0) s0 <= push_data;
          else             s1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          s0  <= (cnt == 2'd2) ? s1 : '0;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            s0 <= s1;
            s1 <= push_data;
          end else begin
            s0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/down_count_monitor.sv
// Checks a 4-bit down-count stream, pulses on terminal count and reports wraps as events.
module down_count_monitor
  import down_cnt_pkg::*;
#(
  parameter int WRAP_W     = 8,
  parameter int DROP_W     = 4,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   count_in,
  input  logic               count_vld,
  input  logic               clr_err,
  output logic               tc,
  output logic               seq_err,
  output logic [DROP_W-1:0]  drop_cnt,
  output mon_state_t         dbg_state,
  down_count_monitor_if.master evt
);
  mon_state_t         state, state_nxt;
  logic [CNT_W-1:0]   prev, prev_nxt, exp_cnt;
  logic [WRAP_W-1:0]  wraps, wraps_nxt;
  logic               tc_nxt, err_nxt, push;
  logic               fifo_full, fifo_valid, pop;
  logic [WRAP_W-1:0]  fifo_head;

  assign dbg_state     = state;
  assign evt.evt_valid = fifo_valid;
  assign evt.evt_wraps = fifo_head;
  assign pop           = fifo_valid && evt.evt_ready;
  assign exp_cnt       = (prev == '0) ? CNT_MAX : prev - CNT_W'(1);

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    wraps_nxt = wraps;
    tc_nxt    = 1'b0;
    err_nxt   = seq_err;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (count_vld) begin
          prev_nxt  = count_in;
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (count_vld) begin
          if (count_in == exp_cnt) begin
            prev_nxt = count_in;
            tc_nxt   = (count_in == '0);
            if (prev == '0) begin
              wraps_nxt = wraps + WRAP_W'(1);
              push      = 1'b1;
            end
          end else if (!(ALLOW_HOLD && (count_in == prev))) begin
            err_nxt   = 1'b1;
            state_nxt = ERROR;
            prev_nxt  = count_in;
          end
        end
      end
      ERROR: begin
        if (clr_err) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      prev     <= '0;
      wraps    <= '0;
      tc       <= 1'b0;
      seq_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      prev    <= prev_nxt;
      wraps   <= wraps_nxt;
      tc      <= tc_nxt;
      seq_err <= err_nxt;
      // An event that finds the FIFO full with nothing leaving is lost; count it.
      if (push && fifo_full && !pop && (drop_cnt != {DROP_W{1'b1}}))
        drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  evt_fifo2 #(.W(WRAP_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (wraps_nxt),
    .full       (fifo_full),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_data  (fifo_head)
  );
endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor with a wrap-event scoreboard.
module tb_down_count_monitor;
  import down_cnt_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  count_in = 4'd0;
  logic        count_vld = 1'b0;
  logic        clr_err = 1'b0;
  logic        tc, seq_err, tc_nh, seq_err_nh;
  logic [3:0]  drop_cnt, drop_cnt_nh;
  mon_state_t  dbg_state, dbg_state_nh;

  int          n_pass = 0, n_fail = 0, n_total = 0, tc_cnt = 0, tc_base;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_w;

  down_count_monitor_if #(.WRAP_W(8)) ev ();
  down_count_monitor_if #(.WRAP_W(8)) ev_nh ();

  always #5 clk = ~clk;

  down_count_monitor #(.WRAP_W(8), .DROP_W(4), .ALLOW_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld), .clr_err(clr_err),
    .tc(tc), .seq_err(seq_err), .drop_cnt(drop_cnt), .dbg_state(dbg_state), .evt(ev.master)
  );

  down_count_monitor #(.WRAP_W(8), .DROP_W(4), .ALLOW_HOLD(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld), .clr_err(clr_err),
    .tc(tc_nh), .seq_err(seq_err_nh), .drop_cnt(drop_cnt_nh), .dbg_state(dbg_state_nh),
    .evt(ev_nh.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic vld);
    count_in  = v;
    count_vld = vld;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and tc counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (tc) tc_cnt = tc_cnt + 1;
    if (rst && ev.evt_valid && ev.evt_ready) begin
      check("evt_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("evt_wraps_order", 32'(ev.evt_wraps), 32'(exp_w));
      end
    end
  end

  initial begin
    ev.evt_ready    = 1'b1;
    ev_nh.evt_ready = 1'b1;

    // Reset state
    rst = 1'b0;
    step(4'd0, 1'b0);
    step(4'd0, 1'b0);
    check("rst_tc", 32'(tc), 0);
    check("rst_seq_err", 32'(seq_err), 0);
    check("rst_evt_valid", 32'(ev.evt_valid), 0);
    check("rst_evt_wraps", 32'(ev.evt_wraps), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // 1,0,15,14
    tc_base = tc_cnt;
    step(4'd1, 1'b1);
    check("t1_tc_idle", 32'(tc), 0);
    step(4'd0, 1'b1);
    check("t1_tc_pulse", 32'(tc), 1);
    exp_q.push_back(8'd1);
    step(4'd15, 1'b1);
    check("t1_tc_off", 32'(tc), 0);
    check("t1_evt_valid", 32'(ev.evt_valid), 1);
    check("t1_evt_wraps", 32'(ev.evt_wraps), 1);
    step(4'd14, 1'b1);
    check("t1_evt_gone", 32'(ev.evt_valid), 0);
    check("t1_seq_err", 32'(seq_err), 0);
    check("t1_tc_count", 32'(tc_cnt - tc_base), 1);

    // Three full down-count passes from a resync at 0
    rst = 1'b0;
    step(4'd0, 1'b0);
    rst = 1'b1;
    step(4'd0, 1'b1);
    tc_base = tc_cnt;
    for (int i = 0; i < 48; i++) begin
      if (i % 16 == 0) exp_q.push_back(8'((i / 16) + 1));
      step(4'(15 - (i % 16)), 1'b1);
    end
    step(4'd0, 1'b0);
    check("t2_tc_count", 32'(tc_cnt - tc_base), 3);
    check("t2_drop", 32'(drop_cnt), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);
    check("t2_seq_err", 32'(seq_err), 0);

    // Back-pressure: four wraps into a two-entry FIFO
    rst = 1'b0;
    step(4'd0, 1'b0);
    rst = 1'b1;
    ev.evt_ready = 1'b0;
    step(4'd0, 1'b1);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    for (int p = 0; p < 4; p++) begin
      for (int v = 15; v >= 0; v--) step(4'(v), 1'b1);
      check("t3_head_stable", 32'(ev.evt_wraps), 1);
      check("t3_valid_held", 32'(ev.evt_valid), 1);
    end
    check("t3_drop", 32'(drop_cnt), 2);
    ev.evt_ready = 1'b1;
    step(4'd0, 1'b0);
    check("t3_second_valid", 32'(ev.evt_valid), 1);
    check("t3_second_wraps", 32'(ev.evt_wraps), 2);
    step(4'd0, 1'b0);
    check("t3_drained", 32'(ev.evt_valid), 0);
    check("t3_q_empty", 32'(exp_q.size()), 0);

    // Reset while an event is pending and held
    ev.evt_ready = 1'b0;
    step(4'd15, 1'b1);
    check("t6_pending", 32'(ev.evt_valid), 1);
    rst = 1'b0;
    step(4'd0, 1'b0);
    check("t6_evt_valid", 32'(ev.evt_valid), 0);
    check("t6_evt_wraps", 32'(ev.evt_wraps), 0);
    check("t6_drop", 32'(drop_cnt), 0);
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    ev.evt_ready = 1'b1;
    step(4'd7, 1'b1);
    check("t6_first_unchecked", 32'(seq_err), 0);
    check("t6_state_track", 32'(dbg_state), 32'(TRACK));
    for (int v = 6; v >= 0; v--) step(4'(v), 1'b1);
    exp_q.push_back(8'd1);
    step(4'd15, 1'b1);
    check("t6_wraps_restart", 32'(ev.evt_wraps), 1);
    step(4'd14, 1'b1);

    // Skip error, stickiness, clear and resync
    rst = 1'b0;
    step(4'd0, 1'b0);
    rst = 1'b1;
    step(4'd10, 1'b1);
    step(4'd9, 1'b1);
    check("t4_no_err", 32'(seq_err), 0);
    step(4'd7, 1'b1);
    check("t4_err_set", 32'(seq_err), 1);
    check("t4_state_err", 32'(dbg_state), 32'(ERROR));
    step(4'd6, 1'b1);
    step(4'd5, 1'b1);
    check("t4_err_sticky", 32'(seq_err), 1);
    clr_err = 1'b1;
    step(4'd0, 1'b0);
    clr_err = 1'b0;
    check("t4_err_clr", 32'(seq_err), 0);
    check("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    step(4'd5, 1'b1);
    step(4'd4, 1'b1);
    check("t4_resync_ok", 32'(seq_err), 0);
    check("t4_state_track", 32'(dbg_state), 32'(TRACK));

    // Hold handling, including a hold at terminal count
    rst = 1'b0;
    step(4'd0, 1'b0);
    rst = 1'b1;
    step(4'd4, 1'b1);
    step(4'd3, 1'b1);
    step(4'd3, 1'b1);
    check("t5_hold_err", 32'(seq_err), 0);
    check("t5_hold_tc", 32'(tc), 0);
    check("t5_nohold_err", 32'(seq_err_nh), 1);
    check("t5_nohold_state", 32'(dbg_state_nh), 32'(ERROR));
    step(4'd2, 1'b1);
    step(4'd1, 1'b1);
    step(4'd0, 1'b1);
    check("t5_tc_at_zero", 32'(tc), 1);
    step(4'd0, 1'b1);
    check("t5_hold_zero_tc", 32'(tc), 0);
    check("t5_hold_zero_err", 32'(seq_err), 0);

    step(4'd0, 1'b0);
    check("final_q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
- Sits directly downstream of the 4-bit down counter and checks the count it produces.
- Confirms the count steps by -1 mod 16, pulses on terminal count (0), and counts wrap-arounds (0 -> 15).
- Each wrap is reported to a consumer over a valid/ready event port, buffered by a 2-entry FIFO.
- Gives the system a checked timebase and a wrap (epoch) count without loading the counter itself.

Parameters:
- WRAP_W, 8, width of the wrap counter and of the event payload.
- DROP_W, 4, width of the saturating dropped-event counter.
- ALLOW_HOLD, 1, 1 = a repeated value on a valid sample is legal (counter stalled); 0 = a repeated value is a sequence error.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- count_in  in  4  count value from the down counter.
- count_vld  in  1  qualifies count_in for this cycle.
- clr_err  in  1  clears a sticky sequence error and resynchronises.
- tc  out  1  one-cycle terminal-count pulse.
- seq_err  out  1  sticky sequence-error flag.
- evt_valid  out  1  wrap event available.
- evt_ready  in  1  consumer accepts the event.
- evt_wraps  out  WRAP_W  wrap count carried by the head event.
- drop_cnt  out  DROP_W  number of events dropped because the FIFO was full; saturates.

Behaviour:
- Reset: synchronous, active-low. rst=0 at a posedge sets:
  - state=IDLE, prev=0, wraps=0, tc=0, seq_err=0;
  - FIFO empty, so evt_valid=0 and evt_wraps=0;
  - drop_cnt=0.
  - Reset has priority over every other input, including mid-handshake; a pending event is discarded.
- All outputs are registered.
- States: IDLE, TRACK, ERROR.
- IDLE:
  - count_vld=1: prev<=count_in, go to TRACK. No check, no tc, no event.
- TRACK, on count_vld=1 (exp = prev-1, 4-bit, so exp of 0 is 15):
  - count_in==exp: legal step; prev<=count_in.
    - If count_in==0: tc=1 in the next cycle.
    - If prev==0 (and so count_in==15): wraps<=wraps+1 mod 2^WRAP_W, and the new wraps value is pushed to the FIFO.
  - count_in==prev and ALLOW_HOLD=1: legal hold; no tc, no event.
  - Any other value, or a hold with ALLOW_HOLD=0: seq_err<=1, go to ERROR, prev<=count_in.
- count_vld=0: no state change; tc=0.
- ERROR:
  - Samples are ignored; seq_err stays high.
  - clr_err=1: seq_err<=0, go to IDLE. wraps is kept and the FIFO keeps draining.
  - clr_err has no effect in IDLE or TRACK.
- tc is high for exactly one cycle per accepted 0 sample. A hold at 0 does not re-pulse.
- Latency: a sample at edge N yields tc / evt_valid / seq_err visible after edge N+1 (one register stage).
- Event FIFO (2 entries):
  - evt_valid = FIFO not empty; evt_wraps = head entry.
  - A transfer happens when evt_valid && evt_ready.
  - While evt_valid && !evt_ready, evt_wraps holds stable.
  - Push while full with no pop: the event is dropped and drop_cnt increments, saturating at all-ones.
  - Push and pop in the same cycle while full: both happen, no drop.
  - Push into empty: the event is visible next cycle. There is no combinational bypass from count_in to evt_*.
- Wrap counter overflow (2^WRAP_W-1 -> 0) is silent; the event still carries 0.

Decomposition:
- Package down_cnt_pkg holds:
  - CNT_W=4 and CNT_MAX=4'hF;
  - typedef enum logic [1:0] {IDLE, TRACK, ERROR} mon_state_t.
- Sub-module evt_fifo2: parameterised-width, 2-entry, valid/ready FIFO.
  - Ports: push, push_data, full, pop, head_valid, head_data; same clk/rst.
- The remaining FSM, compare logic and counters stay in down_count_monitor.

Test Plan:
- Reset, then sequence 1,0,15,14 with count_vld=1, evt_ready=1 -> tc pulses once, one cycle after the 0 sample; evt_valid pulses once after the 15 sample with evt_wraps=1; seq_err=0.
- Run 48 samples of the sequence 15..0 repeated, evt_ready=1 -> 3 wrap events with evt_wraps=1,2,3 in order; tc pulses 3 times; drop_cnt=0.
- evt_ready=0, force 4 wraps -> 2 events held with evt_wraps=1 stable, drop_cnt=2; then evt_ready=1 -> events 1,2 delivered, evt_valid falls after the second.
- In TRACK, count 9 then 7 (skip) -> seq_err=1 next cycle and stays high while further legal samples arrive; pulse clr_err -> seq_err=0; next sample 5 resyncs, then 4 is accepted with no error.
- Hold: sample 3,3 with ALLOW_HOLD=1 -> no error, no tc; same with ALLOW_HOLD=0 -> seq_err=1.
- Assert rst=0 with one event pending and evt_ready=0 -> next cycle evt_valid=0, wraps=0, drop_cnt=0, state IDLE; the first sample after reset is not checked.
